sdf_stage16: RTL and testbench
==============================

Name: sdf_stage16

Overview:
- Radix-2 single-path delay-feedback (SDF) butterfly stage with a 16-entry feedback delay line, for the 32-point FFT pipeline.
- Consumes the twiddle factors (w_r, w_i) and phase code (state) produced by the 16-entry twiddle ROM block running in lockstep.
- Per 32-sample frame: buffers the first half, outputs sums, stores differences, then drains the differences multiplied by the twiddles.
- Registered complex output with a valid strobe.

Parameters:
- DW, 24, data and twiddle width, two's complement.
- FRAC, 8, twiddle fractional bits; 1.0 = 256.
- DEPTH, 16, delay-line length; fixed to half the frame.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input sample strobe; same signal that drives the twiddle ROM.
- din_r  input  DW  input sample, real part.
- din_i  input  DW  input sample, imaginary part.
- w_r  input  DW  twiddle, real part; from ROM, same cycle as the sample.
- w_i  input  DW  twiddle, imaginary part.
- state  input  2  phase code from ROM: 0 fill, 1 butterfly, 2 twiddle drain, 3 idle.
- out_valid  output  1  dout valid strobe.
- dout_r  output  DW  output sample, real part.
- dout_i  output  DW  output sample, imaginary part.

Behaviour:
- Reset (async, rst_n low), applies immediately, including mid-frame:
  - out_valid=0, dout_r=0, dout_i=0.
  - All 16 delay entries = 0.
  - busy=0, k=0.
- Advance condition: adv = in_valid OR busy.
  - busy sets on in_valid.
  - busy clears on the adv cycle where state==2 and k==15 with in_valid=0.
  - No adv: delay line, k and busy hold; out_valid=0 next cycle; dout holds its last value.
- Phase index k (4-bit) increments on every adv cycle with state in {0,1,2}, wrapping 15 to 0. k resets to 0 whenever state changes value.
- Delay line is a 16-deep shift register. head = oldest entry. On each adv cycle in states 0, 1, 2 it shifts once, with new tail:
  - state 0: tail <= din. No output (out_valid=0).
  - state 1: out <= head + din; tail <= head - din. Widths are DW bits, wrap-around, no saturation.
  - state 2: out <= head * W, with W = w_r + j*w_i:
    - re = (hr*w_r - hi*w_i) >>> FRAC
    - im = (hr*w_i + hi*w_r) >>> FRAC
    - Products are full 2*DW signed. Arithmetic shift, truncate toward -inf, keep low DW bits.
    - tail <= din if in_valid, else 0.
  - state 3: no shift, out_valid=0, delay line holds.
- Latency: dout and out_valid are registered, one cycle after the adv cycle that produces them.
- out_valid=1 exactly on cycles following state-1 or state-2 adv cycles, i.e. 32 strobes per frame: 16 sums, then 16 twiddled differences.
- State code sequence 0→1→2→3 is driven by the ROM. Any out-of-order code is obeyed as given per cycle; there is no internal check.
- Simultaneous events:
  - in_valid during state 2 loads the next frame's first half into the tail while draining.
  - state 3 overrides in_valid (sample dropped).

Optional Feature:
- Macro: SDF_ROUND_EN.
  - Defined: state-2 products add 2^(FRAC-1) = 128 before the shift (round half up).
  - Undefined: pure truncation as above.
- States 0 and 1 are unaffected either way.

Test Plan:
- Reset mid-frame: assert rst_n=0 at k=5 of state 1 → out_valid=0, dout=0 immediately. The next frame's first half is buffered from an all-zero line, with no stale outputs.
- Ramp frame: din_r=n, din_i=0 for n=0..31, ROM in lockstep → state-1 outputs dout_r=16,18,…,46, dout_i=0. Differences stored are all -16.
- Same frame, state 2:
  - k=0, W=(256,0) → dout=(-16,0).
  - k=8, W=(0,-256) → dout=(0,16).
  - k=4, W=(181,-181) → dout_r=-12 (floor of -11.3), dout_i=11.
- Truncation vs rounding: x[1]=1, x[17]=0, all others 0. At k=1, W=(251,-50):
  - without SDF_ROUND_EN → dout=(0,-1).
  - with SDF_ROUND_EN → dout=(1,0).
- Stall: drop in_valid for 3 cycles in state 0 with busy=0 → k and delay line hold, no out_valid. Resume gives identical outputs to the unstalled run.
- Drain and idle: after the last input (count 31), in_valid=0 → exactly 16 state-2 strobes. Then busy=0 and state 3: out_valid stays 0 and dout holds its last value for ≥20 cycles.

Source files
------------

// File: rtl/sdf_stage16_if.sv
// Sample/twiddle bus for the 16-entry SDF butterfly stage.
// master drives samples, twiddles and the phase code; slave returns the
// registered complex result with its valid strobe.
interface sdf_stage16_if #(
    parameter int DW = 24
);
    logic                 in_valid;
    logic signed [DW-1:0] din_r;
    logic signed [DW-1:0] din_i;
    logic signed [DW-1:0] w_r;
    logic signed [DW-1:0] w_i;
    logic [1:0]           state;
    logic                 out_valid;
    logic signed [DW-1:0] dout_r;
    logic signed [DW-1:0] dout_i;

    modport master (
        output in_valid, din_r, din_i, w_r, w_i, state,
        input  out_valid, dout_r, dout_i
    );

    modport slave (
        input  in_valid, din_r, din_i, w_r, w_i, state,
        output out_valid, dout_r, dout_i
    );
endinterface

// File: rtl/sdf_stage16.sv
// sdf_stage16: radix-2 single-path delay-feedback butterfly stage with a
// 16-entry feedback line, for the 32-point FFT pipeline.
// Phase code from the twiddle ROM: 0 fill, 1 butterfly, 2 twiddle drain, 3 idle.
// Optional build macro SDF_ROUND_EN: adds half an LSB (2^(FRAC-1)) to the
// drain products before the arithmetic shift (round half up); otherwise the
// products are truncated toward -inf.
module sdf_stage16 #(
    parameter int DW    = 24,
    parameter int FRAC  = 8,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    sdf_stage16_if.slave  io
);
    localparam int PW = 2 * DW;

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_BFLY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_IDLE  = 2'd3;

`ifdef SDF_ROUND_EN
    localparam logic signed [PW-1:0] RND = PW'(1) <<< (FRAC - 1);
`else
    localparam logic signed [PW-1:0] RND = '0;
`endif

    // Control state
    logic       busy_reg;
    logic [3:0] k_reg;
    logic [1:0] state_prev_reg;
    logic [3:0] k_eff;
    logic       adv;
    logic       shift_en;

    // Feedback delay line: entry 0 is the head (oldest), DEPTH-1 the tail
    logic signed [DW-1:0] dl_r_reg [DEPTH];
    logic signed [DW-1:0] dl_i_reg [DEPTH];
    logic signed [DW-1:0] head_r;
    logic signed [DW-1:0] head_i;
    logic signed [DW-1:0] tail_r_next;
    logic signed [DW-1:0] tail_i_next;

    // Butterfly and twiddle datapath
    logic signed [DW-1:0] sum_r;
    logic signed [DW-1:0] sum_i;
    logic signed [PW-1:0] hr_x;
    logic signed [PW-1:0] hi_x;
    logic signed [PW-1:0] wr_x;
    logic signed [PW-1:0] wi_x;
    logic signed [PW-1:0] acc_re;
    logic signed [PW-1:0] acc_im;
    logic signed [DW-1:0] prod_r;
    logic signed [DW-1:0] prod_i;

    // Output registers
    logic                 out_valid_reg;
    logic signed [DW-1:0] dout_r_reg;
    logic signed [DW-1:0] dout_i_reg;

    // Busy keeps the stage advancing through the drain after input stops
    assign adv      = io.in_valid | busy_reg;
    assign shift_en = adv & (io.state != ST_IDLE);
    // A new phase code always starts counting from zero
    assign k_eff    = (io.state != state_prev_reg) ? 4'd0 : k_reg;

    assign head_r = dl_r_reg[0];
    assign head_i = dl_i_reg[0];

    assign sum_r = head_r + io.din_r;
    assign sum_i = head_i + io.din_i;

    // Full-width signed products: sign-extend everything to 2*DW first
    assign hr_x = {{DW{head_r[DW-1]}}, head_r};
    assign hi_x = {{DW{head_i[DW-1]}}, head_i};
    assign wr_x = {{DW{io.w_r[DW-1]}}, io.w_r};
    assign wi_x = {{DW{io.w_i[DW-1]}}, io.w_i};

    assign acc_re = hr_x * wr_x - hi_x * wi_x + RND;
    assign acc_im = hr_x * wi_x + hi_x * wr_x + RND;
    assign prod_r = DW'(acc_re >>> FRAC);
    assign prod_i = DW'(acc_im >>> FRAC);

    // Select what enters the tail of the delay line for the current phase
    always_comb begin
        tail_r_next = '0;
        tail_i_next = '0;
        case (io.state)
            ST_FILL: begin
                tail_r_next = io.din_r;
                tail_i_next = io.din_i;
            end
            ST_BFLY: begin
                tail_r_next = head_r - io.din_r;
                tail_i_next = head_i - io.din_i;
            end
            ST_DRAIN: begin
                if (io.in_valid) begin
                    tail_r_next = io.din_r;
                    tail_i_next = io.din_i;
                end
            end
            default: begin
                tail_r_next = '0;
                tail_i_next = '0;
            end
        endcase
    end

    // Phase index, busy flag and previous phase code tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg       <= 1'b0;
            k_reg          <= 4'd0;
            state_prev_reg <= 2'd0;
        end else begin
            state_prev_reg <= io.state;
            if (io.in_valid) begin
                busy_reg <= 1'b1;
            end else if (adv && io.state == ST_DRAIN && k_eff == 4'd15) begin
                busy_reg <= 1'b0;
            end
            if (shift_en) begin
                k_reg <= k_eff + 4'd1;
            end else begin
                k_reg <= k_eff;
            end
        end
    end

    // One register stage per delay entry; the tail takes the phase-selected value
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_dl
            if (gi == DEPTH - 1) begin : g_tail
                // Tail entry loads the new value on each shift
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        dl_r_reg[gi] <= '0;
                        dl_i_reg[gi] <= '0;
                    end else if (shift_en) begin
                        dl_r_reg[gi] <= tail_r_next;
                        dl_i_reg[gi] <= tail_i_next;
                    end
                end
            end else begin : g_mid
                // Inner entries move one step toward the head on each shift
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        dl_r_reg[gi] <= '0;
                        dl_i_reg[gi] <= '0;
                    end else if (shift_en) begin
                        dl_r_reg[gi] <= dl_r_reg[gi+1];
                        dl_i_reg[gi] <= dl_i_reg[gi+1];
                    end
                end
            end
        end
    endgenerate

    // Registered result: sums in the butterfly phase, twiddled differences in the drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            dout_r_reg    <= '0;
            dout_i_reg    <= '0;
        end else begin
            out_valid_reg <= shift_en && (io.state == ST_BFLY || io.state == ST_DRAIN);
            if (shift_en && io.state == ST_BFLY) begin
                dout_r_reg <= sum_r;
                dout_i_reg <= sum_i;
            end else if (shift_en && io.state == ST_DRAIN) begin
                dout_r_reg <= prod_r;
                dout_i_reg <= prod_i;
            end
        end
    end

    assign io.out_valid = out_valid_reg;
    assign io.dout_r    = dout_r_reg;
    assign io.dout_i    = dout_i_reg;
endmodule

// File: tb/tb_sdf_stage16.sv
// Bench for sdf_stage16: a frame-level model (sums of x[n]+x[n+16], then
// (x[k]-x[k+16])*W[k] scaled by 2^-8) feeds a cycle-tagged expectation queue
// that one monitor checks every cycle; literal values pin the model.
module tb_sdf_stage16;
    localparam int DW = 24;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdf_stage16_if #(.DW(DW)) bus();

    sdf_stage16 #(.DW(DW), .FRAC(8), .DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    typedef struct {
        int          due;
        logic [23:0] r;
        logic [23:0] i;
    } exp_t;

    typedef struct packed {
        logic [23:0] r;
        logic [23:0] i;
    } cpx_t;

`ifdef SDF_ROUND_EN
    localparam longint RND = 128;
`else
    localparam longint RND = 0;
`endif

    exp_t        exp_q[$];
    cpx_t        log_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [23:0] last_r = '0;
    logic [23:0] last_i = '0;
    int          xr[6][32];
    int          xi[6][32];
    int          wr_tab[16];
    int          wi_tab[16];
    bit          loaded[6];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint sx24(input longint v);
        logic [23:0] t;
        t = v[23:0];
        return longint'($signed(t));
    endfunction

    function automatic logic [23:0] w24(input longint v);
        return v[23:0];
    endfunction

    task automatic chk(input string name, input logic [23:0] ar, input logic [23:0] ai,
                       input logic [23:0] er, input logic [23:0] ei);
        total++;
        if (ar !== er || ai !== ei) begin
            bad++;
            $display("FAIL %s @cyc %0d: got (%0d,%0d) want (%0d,%0d)", name, cyc,
                     $signed(ar), $signed(ai), $signed(er), $signed(ei));
        end
    endtask

    task automatic lit(input string name, input int idx, input int er, input int ei);
        if (idx >= log_q.size()) begin
            total++;
            bad++;
            $display("FAIL %s: strobe %0d never seen, have %0d", name, idx, log_q.size());
        end else begin
            chk(name, log_q[idx].r, log_q[idx].i, 24'(er), 24'(ei));
        end
    endtask

    // Monitor: every cycle either a tagged expectation matches or dout holds
    always @(negedge clk) begin
        if (!rst_n) begin
            last_r = '0;
            last_i = '0;
        end else if (bus.out_valid) begin
            if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
                total++;
                bad++;
                $display("FAIL valid_timing @cyc %0d: out_valid=1 required 0", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("dout", bus.dout_r, bus.dout_i, mon_e.r, mon_e.i);
            end
            log_q.push_back('{r: bus.dout_r, i: bus.dout_i});
            last_r = bus.dout_r;
            last_i = bus.dout_i;
        end else begin
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                total++;
                bad++;
                $display("FAIL missing_valid @cyc %0d: out_valid=0 required 1", cyc);
                void'(exp_q.pop_front());
            end
            chk("hold", bus.dout_r, bus.dout_i, last_r, last_i);
        end
    end

    task automatic drive(input bit v, input int dr, input int di, input int wr, input int wi,
                         input logic [1:0] st);
        bus.in_valid = v;
        bus.din_r    = 24'(dr);
        bus.din_i    = 24'(di);
        bus.w_r      = 24'(wr);
        bus.w_i      = 24'(wi);
        bus.state    = st;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) drive(1'b0, 0, 0, 0, 0, 2'd3);
    endtask

    task automatic push_exp(input logic [23:0] r, input logic [23:0] i);
        exp_q.push_back('{due: cyc + 1, r: r, i: i});
    endtask

    // One frame: optional fill, 16 butterflies, 16 drains (optionally loading
    // the next frame's first half). rst_at >= 0 resets during that butterfly.
    task automatic run_frame(input int f, input bit do_fill, input bit overlap, input int rst_at);
        longint hr, hi, dr, di, pr, pi;
        if (do_fill) begin
            for (int n = 0; n < 16; n++) drive(1'b1, xr[f][n], xi[f][n], 0, 0, 2'd0);
        end
        for (int n = 0; n < 16; n++) begin
            hr = (do_fill || loaded[f]) ? longint'(xr[f][n]) : 0;
            hi = (do_fill || loaded[f]) ? longint'(xi[f][n]) : 0;
            if (n == rst_at) begin
                bus.in_valid = 1'b1;
                bus.din_r    = 24'(xr[f][16+n]);
                bus.din_i    = 24'(xi[f][16+n]);
                bus.state    = 2'd1;
                @(negedge clk);
                #1;
                rst_n = 1'b0;
                #1;
                total++;
                if (bus.out_valid !== 1'b0 || bus.dout_r !== '0 || bus.dout_i !== '0) begin
                    bad++;
                    $display("FAIL rst_async: got v=%0b (%0d,%0d) want v=0 (0,0)",
                             bus.out_valid, $signed(bus.dout_r), $signed(bus.dout_i));
                end
                exp_q.delete();
                bus.in_valid = 1'b0;
                bus.state    = 2'd3;
                @(posedge clk);
                @(negedge clk);
                #1;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            push_exp(w24(hr + xr[f][16+n]), w24(hi + xi[f][16+n]));
            drive(1'b1, xr[f][16+n], xi[f][16+n], 0, 0, 2'd1);
        end
        for (int k = 0; k < 16; k++) begin
            hr = (do_fill || loaded[f]) ? longint'(xr[f][k]) : 0;
            hi = (do_fill || loaded[f]) ? longint'(xi[f][k]) : 0;
            dr = sx24(hr - xr[f][16+k]);
            di = sx24(hi - xi[f][16+k]);
            pr = (dr * wr_tab[k] - di * wi_tab[k] + RND) >>> 8;
            pi = (dr * wi_tab[k] + di * wr_tab[k] + RND) >>> 8;
            push_exp(w24(pr), w24(pi));
            if (overlap) drive(1'b1, xr[f+1][k], xi[f+1][k], wr_tab[k], wi_tab[k], 2'd2);
            else         drive(1'b0, 0, 0, wr_tab[k], wi_tab[k], 2'd2);
        end
        if (overlap) loaded[f+1] = 1'b1;
    endtask

    initial begin
        wr_tab = '{256, 251, 237, 213, 181, 142, 98, 50, 0, -50, -98, -142, -181, -213, -237, -251};
        wi_tab = '{0, -50, -98, -142, -181, -213, -237, -251, -256, -251, -237, -213, -181, -142, -98, -50};
        for (int n = 0; n < 32; n++) begin
            xr[0][n] = n;                        xi[0][n] = 0;
            xr[1][n] = (n == 1) ? 1 : 0;         xi[1][n] = 0;
            xr[2][n] = (n * 37) % 101 - 50;      xi[2][n] = (n * 13) % 29 - 14;
            xr[3][n] = 1000 - n * 70;            xi[3][n] = n * n;
            xr[4][n] = n * 5 - 40;               xi[4][n] = 7 - n * 3;
            xr[5][n] = (n < 16) ? 8388600 - n : 100 + n;
            xi[5][n] = (n < 16) ? -8388600 + n : -(200 + n);
        end
        foreach (loaded[f]) loaded[f] = 1'b0;

        bus.in_valid = 1'b0;
        bus.din_r = '0; bus.din_i = '0; bus.w_r = '0; bus.w_i = '0;
        bus.state = 2'd3;
        #12;
        chk("reset_dout", bus.dout_r, bus.dout_i, 24'd0, 24'd0);
        chk("reset_valid", {23'd0, bus.out_valid}, 24'd0, 24'd0, 24'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        // Stall before the first sample: busy is clear so nothing may move
        for (int c = 0; c < 3; c++) drive(1'b0, 999, -999, 0, 0, 2'd0);
        run_frame(0, 1'b1, 1'b0, -1);
        idle(10);
        drive(1'b1, 777, -777, 0, 0, 2'd3);   // state 3 drops the sample
        idle(10);
`ifdef SDF_ROUND_EN
        chk("idle_hold_last", bus.dout_r, bus.dout_i, 24'(16), 24'(3));
`else
        chk("idle_hold_last", bus.dout_r, bus.dout_i, 24'(15), 24'(3));
`endif

        run_frame(1, 1'b1, 1'b1, -1);
        run_frame(2, 1'b0, 1'b0, -1);
        idle(5);
        run_frame(3, 1'b1, 1'b0, 5);
        idle(3);
        run_frame(4, 1'b0, 1'b0, -1);
        idle(3);
        run_frame(5, 1'b1, 1'b0, -1);
        idle(5);

        lit("ramp_sum0",  0, 16, 0);
        lit("ramp_sum15", 15, 46, 0);
        lit("ramp_k0",    16, -16, 0);
`ifdef SDF_ROUND_EN
        lit("ramp_k4",    20, -11, 11);
        lit("trunc_k1",   49, 1, 0);
`else
        lit("ramp_k4",    20, -12, 11);
        lit("trunc_k1",   49, 0, -1);
`endif
        lit("ramp_k8",    24, 0, 16);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d expected outputs never seen, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
